tone_synth: RTL
===============

// Module: tone_synth
// PURPOSE
//  Parametrised keyboard tone generator, successor to the single-octave switch player.
//  Samples up to 12 active-low key inputs; debounces them; picks one note by fixed priority.
//  Drives a square wave on the speaker pin in one of 4 octaves.
//  Adds a timed release tail and mute, plus note-status outputs for LEDs and the display.
// PARAMETERS
//  CLK_HZ       12000000  input clock frequency in Hz; sets the half-period table
//  NUM_KEYS     12        number of keys, 1..12; key i = semitone i above A (A,A#,B,C..G#)
//  DEBOUNCE_CYC 120000    cycles the synced key vector must be stable before it is accepted
//  RELEASE_CYC  2400000   cycles the last note keeps sounding after all keys are released
//  DIV_W        22        width of the half-period counter
// PORTS
//  clk         in   1         system clock; all logic on posedge
//  rst_n       in   1         synchronous, active-low reset
//  key_n       in   NUM_KEYS  raw key inputs; 0 = pressed; asynchronous to clk
//  octave      in   2         octave shift 0..3; each step doubles the pitch
//  mute        in   1         1 = speaker held low; sequencing continues
//  speaker     out  1         square-wave output, registered
//  led         out  NUM_KEYS  one-hot of the sounding note; 0 when idle
//  note_valid  out  1         1 while in PLAY or RELEASE
//  note_idx    out  4         index of the sounding note; 0 when idle
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - state=IDLE; speaker, led, note_valid and note_idx = 0.
//   - Tone counter and release counter = 0; synced and accepted key vectors = all 1s.
//   - Reset applies mid-note; the first cycle after reset is normal IDLE.
//  Input path:
//   - 2-flop synchroniser on key_n.
//   - The debounce counter restarts whenever the synced vector changes.
//   - When the vector has been unchanged for DEBOUNCE_CYC consecutive cycles, it is copied to key_q.
//   - Glitches shorter than DEBOUNCE_CYC never reach key_q.
//  Note select (combinational on key_q):
//   - Lowest index with key_q[i]=0 wins.
//   - any_key = NOT &key_q.
//  Half-period:
//   - HP[i] = CLK_HZ/(2*f_i), integer truncated.
//   - f_i = 440,466,494,523,554,587,622,659,698,740,784,831 Hz.
//   - Effective half-period = HP[i] >> octave.
//  State machine (3 states):
//   - IDLE: any_key -> PLAY. Latch sel into note_idx, load tone_cnt = HPeff-1, tone_q = 0.
//   - PLAY, any_key, same note: tone_cnt counts down. At 0, toggle tone_q and reload HPeff-1.
//   - PLAY, any_key, sel differs from the latched note: latch the new note and reload tone_cnt = HPeff-1. tone_q is not toggled that cycle.
//   - PLAY, no key -> RELEASE. Load rel_cnt = RELEASE_CYC-1; the tone continues on the latched note.
//   - RELEASE, any_key -> PLAY. Same latch and reload as from IDLE, but tone_q keeps its level.
//   - RELEASE, rel_cnt==0 -> IDLE. tone_q = 0.
//   - RELEASE otherwise: rel_cnt decrements; the tone keeps running.
//  Timing:
//   - Output period = 2*HPeff cycles.
//   - A change on octave takes effect at the next reload, with no glitch mid-half-period.
//   - Press latency: key_n edge -> state leaves IDLE 2+DEBOUNCE_CYC+1 cycles later.
//  Outputs:
//   - speaker <= tone_q & ~mute, registered, so one cycle behind tone_q.
//   - led = one-hot(note_idx) when state!=IDLE, else 0.
//   - note_valid = (state!=IDLE).
//  Widths:
//   - HP table entries are truncated to DIV_W.
//   - A table value that does not fit in DIV_W is a parameter error; flag it with an elaboration-time check.
//   - Keys at or above NUM_KEYS do not exist and are never selected.
// TESTING
//  Sim parameters: CLK_HZ=12000000, DEBOUNCE_CYC=4, RELEASE_CYC=1000.
//  T1 reset:
//   - Stimulus: key0 playing, then rst_n=0 for 3 cycles.
//   - Required: speaker=0, led=0, note_valid=0 at the first reset edge; stays IDLE after release.
//  T2 single key:
//   - Stimulus: key_n=12'hFFE, octave=0.
//   - Required: note_valid rises 7 cycles after the edge; led=12'h001; speaker toggles every 13636 cycles.
//   - Then octave=3: speaker toggles every 1704 cycles from the next reload.
//  T3 priority:
//   - Stimulus: keys 0 and 3 pressed.
//   - Required: note_idx=0; after key0 is released and debounced, note_idx=3 and speaker toggles every 11472 cycles.
//  T4 release tail:
//   - Stimulus: release all keys.
//   - Required: tone continues for 1000 cycles; then note_valid=0, speaker=0, led=0.
//   - Repeat, but press key11 at release cycle 500: back to PLAY without passing IDLE, half-period 7220.
//  T5 bounce:
//   - Stimulus: key_n[2] toggles every 2 cycles for 40 cycles, then returns high.
//   - Required: note_valid stays 0 throughout.
//  T6 mute:
//   - Stimulus: mute=1 during PLAY.
//   - Required: speaker=0 one cycle later; led and note_valid unchanged.
//   - After mute=0: speaker resumes in phase with tone_q.

Source files
------------

// File: rtl/tone_synth.sv
// tone_synth: debounced keyboard square-wave generator with octave shift,
// release tail, mute and note-status outputs.
module tone_synth #(
    parameter int CLK_HZ       = 12000000,
    parameter int NUM_KEYS     = 12,
    parameter int DEBOUNCE_CYC = 120000,
    parameter int RELEASE_CYC  = 2400000,
    parameter int DIV_W        = 22
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [1:0]          octave,
    input  logic                mute,
    output logic                speaker,
    output logic [NUM_KEYS-1:0] led,
    output logic                note_valid,
    output logic [3:0]          note_idx
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam int REL_W = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;

    // Semitone frequencies starting at A4, in Hz.
    localparam int FREQ [12] = '{440, 466, 494, 523, 554, 587,
                                 622, 659, 698, 740, 784, 831};

    // Elaboration-time parameter sanity checks.
    if (NUM_KEYS < 1 || NUM_KEYS > 12) begin : g_bad_keys
        $error("tone_synth: NUM_KEYS must be 1..12");
    end
    for (genvar g = 0; g < NUM_KEYS && g < 12; g++) begin : g_hp_chk
        if (longint'(CLK_HZ / (2 * FREQ[g])) >= (longint'(1) << DIV_W)) begin : g_bad_hp
            $error("tone_synth: half-period table entry does not fit in DIV_W");
        end
    end

    typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;

    state_t              state, state_d;
    logic [NUM_KEYS-1:0] key_s1, key_s2, key_c, key_q;
    logic [DB_W-1:0]     db_cnt;
    logic [DIV_W-1:0]    tone_cnt, tone_cnt_d;
    logic [REL_W-1:0]    rel_cnt, rel_cnt_d;
    logic                tone_q, tone_d;
    logic [3:0]          note_d;
    logic [3:0]          sel;
    logic                any_key;
    logic [DIV_W-1:0]    hp_sel, hp_cur;
    logic [DIV_W-1:0]    run_cnt;
    logic                run_q;

    // Half-period lookup for a note index; out-of-range indices give 0.
    function automatic logic [DIV_W-1:0] hp_lookup(input logic [3:0] i);
        hp_lookup = '0;
        for (int k = 0; k < 12; k++)
            if (i == 4'(k)) hp_lookup = DIV_W'(CLK_HZ / (2 * FREQ[k]));
    endfunction

    // Reload value for a half-period; a zero half-period reloads 0 rather than wrapping.
    function automatic logic [DIV_W-1:0] reload(input logic [DIV_W-1:0] hp);
        reload = (hp == '0) ? '0 : hp - 1'b1;
    endfunction

    // Synchronise raw keys, then accept the vector once stable for DEBOUNCE_CYC samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_s1 <= '1;
            key_s2 <= '1;
            key_c  <= '1;
            key_q  <= '1;
            db_cnt <= '0;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
            if (key_s2 != key_c) begin
                key_c  <= key_s2;
                db_cnt <= DB_W'(1);
            end else if (db_cnt >= DB_W'(DEBOUNCE_CYC - 1)) begin
                key_q <= key_c;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Fixed priority: lowest existing pressed key wins.
    always_comb begin
        sel     = '0;
        any_key = 1'b0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (!key_q[i]) begin
                sel     = 4'(i);
                any_key = 1'b1;
            end
        end
    end

    // Octave-shifted half-periods for the candidate and the latched note, plus free-running step.
    always_comb begin
        hp_sel = hp_lookup(sel) >> octave;
        hp_cur = hp_lookup(note_idx) >> octave;
        if (tone_cnt == '0) begin
            run_q   = ~tone_q;
            run_cnt = reload(hp_cur);
        end else begin
            run_q   = tone_q;
            run_cnt = tone_cnt - 1'b1;
        end
    end

    // Next-state logic for IDLE / PLAY / RELEASE sequencing.
    always_comb begin
        state_d    = state;
        note_d     = note_idx;
        tone_cnt_d = tone_cnt;
        tone_d     = tone_q;
        rel_cnt_d  = rel_cnt;
        case (state)
            IDLE: begin
                if (any_key) begin
                    state_d    = PLAY;
                    note_d     = sel;
                    tone_cnt_d = reload(hp_sel);
                    tone_d     = 1'b0;
                end
            end
            PLAY: begin
                if (!any_key) begin
                    state_d    = RELEASE;
                    rel_cnt_d  = REL_W'(RELEASE_CYC - 1);
                    tone_cnt_d = run_cnt;
                    tone_d     = run_q;
                end else if (sel != note_idx) begin
                    note_d     = sel;
                    tone_cnt_d = reload(hp_sel);
                end else begin
                    tone_cnt_d = run_cnt;
                    tone_d     = run_q;
                end
            end
            RELEASE: begin
                if (any_key) begin
                    state_d    = PLAY;
                    note_d     = sel;
                    tone_cnt_d = reload(hp_sel);
                end else if (rel_cnt == '0) begin
                    state_d    = IDLE;
                    note_d     = '0;
                    tone_cnt_d = '0;
                    tone_d     = 1'b0;
                end else begin
                    rel_cnt_d  = rel_cnt - 1'b1;
                    tone_cnt_d = run_cnt;
                    tone_d     = run_q;
                end
            end
            default: begin
                state_d    = IDLE;
                note_d     = '0;
                tone_cnt_d = '0;
                tone_d     = 1'b0;
            end
        endcase
    end

    // State, tone and speaker registers; speaker trails tone_q by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            note_idx <= '0;
            tone_cnt <= '0;
            tone_q   <= 1'b0;
            rel_cnt  <= '0;
            speaker  <= 1'b0;
        end else begin
            state    <= state_d;
            note_idx <= note_d;
            tone_cnt <= tone_cnt_d;
            tone_q   <= tone_d;
            rel_cnt  <= rel_cnt_d;
            speaker  <= tone_q & ~mute;
        end
    end

    // Status outputs: one-hot LED of the sounding note, valid while not idle.
    always_comb begin
        note_valid = (state != IDLE);
        for (int i = 0; i < NUM_KEYS; i++)
            led[i] = (state != IDLE) && (note_idx == 4'(i));
    end

endmodule
